// File: rtl/nf_cpu_packer_avlstrm_pkg.sv
`default_nettype none
// nf_cpu_packer_avlstrm_pkg: shared types, field offsets and flit builders for the CPU packer.
// Rev 1.0
package nf_cpu_packer_avlstrm_pkg;

  localparam int DATA_W         = 512;
  localparam int EMPTY_W        = 6;
  localparam int CNT_W          = 16;
  localparam int SEQ_W          = 32;
  localparam int RULE_ID_W      = 16;
  localparam int RULES_PER_FLIT = 32;
  localparam logic [15:0] MAGIC_DEFAULT = 16'hC0DE;

  localparam int HDR_META_MSB     = 511;
  localparam int HDR_MAGIC_LSB    = 0;
  localparam int TRL_RULE_CNT_LSB = 496;
  localparam int TRL_PKT_CNT_LSB  = 480;
  localparam int TRL_SEQ_LSB      = 448;
  localparam int TRL_EMPTY_LSB    = 442;
  localparam int TRL_OVF_BIT      = 441;
  localparam int TRL_ERR_BIT      = 440;

  typedef struct packed {
    logic [31:0] flow_id;
    logic [15:0] rule_grp;
    logic [15:0] src_port;
    logic [63:0] timestamp;
  } metadata_t;

  localparam int META_W = $bits(metadata_t);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PKT     = 3'd2,
    ST_RULE    = 3'd3,
    ST_TRAILER = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] build_header(input metadata_t meta,
                                                     input logic [15:0] magic);
    logic [DATA_W-1:0] d;
    d = '0;
    d[HDR_META_MSB -: META_W] = meta;
    d[HDR_MAGIC_LSB +: 16]    = magic;
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] build_trailer(input logic [CNT_W-1:0]   rule_cnt,
                                                      input logic [CNT_W-1:0]   pkt_cnt,
                                                      input logic [SEQ_W-1:0]   seq,
                                                      input logic [EMPTY_W-1:0] empty,
                                                      input logic               ovf,
                                                      input logic               err);
    logic [DATA_W-1:0] d;
    d = '0;
    d[TRL_RULE_CNT_LSB +: CNT_W] = rule_cnt;
    d[TRL_PKT_CNT_LSB +: CNT_W]  = pkt_cnt;
    d[TRL_SEQ_LSB +: SEQ_W]      = seq;
    d[TRL_EMPTY_LSB +: EMPTY_W]  = empty;
    d[TRL_OVF_BIT]               = ovf;
    d[TRL_ERR_BIT]               = err;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nf_cpu_packer_avlstrm_rule_popcount.sv
`default_nettype none
// rule_popcount: number of nonzero 16-bit rule-ID lanes in one 512-bit rule flit.
// Rev 1.0
module rule_popcount
  import nf_cpu_packer_avlstrm_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [5:0]        count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < RULES_PER_FLIT; i++) begin
      count = count + {5'd0, |data[i*RULE_ID_W +: RULE_ID_W]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/nf_cpu_packer_avlstrm.sv
`default_nettype none
// nf_cpu_packer_avlstrm: packs meta, packet and rule-ID streams into header/pkt/rule/trailer flits.
// Rev 1.0
module nf_cpu_packer_avlstrm
  import nf_cpu_packer_avlstrm_pkg::*;
#(
  parameter logic [15:0] MAGIC          = MAGIC_DEFAULT,
  parameter int          MAX_RULE_FLITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_pkt_data,
  input  logic                in_pkt_valid,
  output logic                in_pkt_ready,
  input  logic                in_pkt_sop,
  input  logic                in_pkt_eop,
  input  logic [EMPTY_W-1:0]  in_pkt_empty,
  input  metadata_t           in_meta_data,
  input  logic                in_meta_valid,
  output logic                in_meta_ready,
  input  logic [DATA_W-1:0]   in_usr_data,
  input  logic                in_usr_valid,
  output logic                in_usr_ready,
  input  logic                in_usr_eop,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic [EMPTY_W-1:0]  out_empty,
  output logic [31:0]         stats_pkt,
  output logic [31:0]         stats_rule,
  output logic [31:0]         stats_rule_ovf,
  output logic [31:0]         stats_proto_err
);

  localparam int RIDX_W = $clog2(MAX_RULE_FLITS + 1);

  state_t             state, state_nxt;
  logic               run;
  logic               can_load;
  logic               meta_acc, pkt_acc, usr_acc;
  logic               rule_room, rule_fwd, rule_drop, trl_load;
  logic               out_acc, trl_acc, pkt_bad;
  logic [CNT_W-1:0]   pkt_cnt, rule_cnt;
  logic [RIDX_W-1:0]  rule_idx;
  logic [EMPTY_W-1:0] pkt_empty;
  logic               ovf, err;
  logic [SEQ_W-1:0]   seq;
  logic [5:0]         pop;

  rule_popcount u_rule_popcount (
    .data  (in_usr_data),
    .count (pop)
  );

  // Keeps all readies low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (meta_acc) state_nxt = ST_HDR;
      ST_HDR:     if (pkt_acc) state_nxt = in_pkt_eop ? ST_RULE : ST_PKT;
      ST_PKT:     if (pkt_acc && in_pkt_eop) state_nxt = ST_RULE;
      ST_RULE:    if (usr_acc && in_usr_eop) state_nxt = ST_TRAILER;
      ST_TRAILER: if (trl_load) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign can_load  = ~out_valid | out_ready;
  assign rule_room = (rule_idx < RIDX_W'(MAX_RULE_FLITS));

  always_comb begin
    in_meta_ready = 1'b0;
    in_pkt_ready  = 1'b0;
    in_usr_ready  = 1'b0;
    trl_load      = 1'b0;
    case (state)
      ST_IDLE:        in_meta_ready = run & can_load;
      ST_HDR, ST_PKT: in_pkt_ready  = run & can_load;
      // Dropped rule flits never touch the output register, so they drain freely.
      ST_RULE:        in_usr_ready  = run & (rule_room ? can_load : 1'b1);
      ST_TRAILER:     trl_load      = run & can_load;
      default: ;
    endcase
  end

  assign meta_acc  = in_meta_valid & in_meta_ready;
  assign pkt_acc   = in_pkt_valid & in_pkt_ready;
  assign usr_acc   = in_usr_valid & in_usr_ready;
  assign rule_fwd  = usr_acc & rule_room;
  assign rule_drop = usr_acc & ~rule_room;
  assign out_acc   = out_valid & out_ready;
  assign trl_acc   = out_acc & out_eop;
  assign pkt_bad   = (state == ST_HDR) ? ~in_pkt_sop : in_pkt_sop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (meta_acc) begin
      out_valid <= 1'b1;
      out_data  <= build_header(in_meta_data, MAGIC);
      out_sop   <= 1'b1;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (pkt_acc) begin
      out_valid <= 1'b1;
      out_data  <= in_pkt_data;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (rule_fwd) begin
      out_valid <= 1'b1;
      out_data  <= in_usr_data;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
    end else if (trl_load) begin
      out_valid <= 1'b1;
      out_data  <= build_trailer(rule_cnt, pkt_cnt, seq, pkt_empty, ovf, err);
      out_sop   <= 1'b0;
      out_eop   <= 1'b1;
      out_empty <= '0;
    end else if (out_acc) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      rule_cnt  <= '0;
      rule_idx  <= '0;
      pkt_empty <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (meta_acc) begin
      pkt_cnt   <= '0;
      rule_cnt  <= '0;
      rule_idx  <= '0;
      pkt_empty <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (pkt_acc) begin
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 16'd1;
        if (in_pkt_eop)    pkt_empty <= in_pkt_empty;
        if (pkt_bad)       err <= 1'b1;
      end
      if (rule_fwd) begin
        rule_cnt <= rule_cnt + {10'd0, pop};
        rule_idx <= rule_idx + RIDX_W'(1);
      end
      if (rule_drop) ovf <= 1'b1;
    end
  end

  // Per-packet events count once: only the first error or first drop bumps the stat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq             <= '0;
      stats_pkt       <= '0;
      stats_rule      <= '0;
      stats_rule_ovf  <= '0;
      stats_proto_err <= '0;
    end else begin
      if (trl_acc) begin
        seq       <= seq + 32'd1;
        stats_pkt <= stats_pkt + 32'd1;
      end
      if (rule_fwd)                  stats_rule      <= stats_rule + {26'd0, pop};
      if (rule_drop && !ovf)         stats_rule_ovf  <= stats_rule_ovf + 32'd1;
      if (pkt_acc && pkt_bad && !err) stats_proto_err <= stats_proto_err + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nf_cpu_packer_avlstrm.sv
`default_nettype none
// tb_nf_cpu_packer_avlstrm: randomized bench with a packet-level reference model of the packer.
// Rev 1.0
module tb_nf_cpu_packer_avlstrm;
  import nf_cpu_packer_avlstrm_pkg::*;

  localparam int MAXR = 4;

  typedef struct packed {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [511:0] in_pkt_data = '0;
  logic in_pkt_valid = 1'b0, in_pkt_ready, in_pkt_sop = 1'b0, in_pkt_eop = 1'b0;
  logic [5:0] in_pkt_empty = '0;
  metadata_t in_meta_data = '0;
  logic in_meta_valid = 1'b0, in_meta_ready;
  logic [511:0] in_usr_data = '0;
  logic in_usr_valid = 1'b0, in_usr_ready, in_usr_eop = 1'b0;
  logic [511:0] out_data;
  logic out_valid, out_ready = 1'b0, out_sop, out_eop;
  logic [5:0] out_empty;
  logic [31:0] stats_pkt, stats_rule, stats_rule_ovf, stats_proto_err;

  nf_cpu_packer_avlstrm #(.MAGIC(16'hC0DE), .MAX_RULE_FLITS(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .in_usr_data(in_usr_data), .in_usr_valid(in_usr_valid), .in_usr_ready(in_usr_ready),
    .in_usr_eop(in_usr_eop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .stats_pkt(stats_pkt), .stats_rule(stats_rule),
    .stats_rule_ovf(stats_rule_ovf), .stats_proto_err(stats_proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int p_valid = 100, p_ready = 100;
  logic [127:0] meta_q[$];
  flit_t pkt_q[$], usr_q[$], exp_q[$];
  // reference-model state
  logic [31:0] m_seq = 0, m_pkt = 0, m_rule = 0, m_ovf = 0, m_perr = 0;
  // per-phase observations
  int ph_first_out, ph_first_meta, ph_last_acc, ph_nacc, ph_pkt_fires;
  bit hold_v = 0;
  flit_t hold_f;

  task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // mode: 0 random IDs (half empty), 1 all IDs nonzero, 2 IDs {7,0,9,0...}
  // err_kind: 0 clean, 1 first flit lacks sop, 2 second flit carries sop
  task automatic gen_pkt(input int n_pkt, input int n_rule, input int mode,
                         input int err_kind, input int last_empty);
    logic [127:0] meta;
    logic [511:0] h, t, d;
    flit_t f;
    int rcnt, nz, le;
    bit err, ovf;
    meta = {$urandom, $urandom, $urandom, $urandom};
    meta_q.push_back(meta);
    h = '0;
    h[511:384] = meta;
    h[15:0] = 16'hC0DE;
    f.d = h; f.sop = 1'b1; f.eop = 1'b0; f.empty = '0;
    exp_q.push_back(f);
    err = (err_kind == 1) || (err_kind == 2 && n_pkt >= 2);
    le = (last_empty >= 0) ? last_empty : int'($urandom_range(63));
    for (int i = 0; i < n_pkt; i++) begin
      f.d = rand512();
      f.sop = (i == 0);
      if (err_kind == 1 && i == 0) f.sop = 1'b0;
      if (err_kind == 2 && i == 1) f.sop = 1'b1;
      f.eop = (i == n_pkt - 1);
      f.empty = f.eop ? 6'(le) : 6'($urandom_range(63));
      pkt_q.push_back(f);
      f.sop = 1'b0; f.eop = 1'b0; f.empty = '0;
      exp_q.push_back(f);
    end
    rcnt = 0;
    for (int j = 0; j < n_rule; j++) begin
      d = '0;
      for (int k = 0; k < 32; k++) begin
        if (mode == 1) d[k*16 +: 16] = 16'($urandom_range(65535, 1));
        else if (mode == 0 && $urandom_range(1) == 1) d[k*16 +: 16] = 16'($urandom_range(65535, 1));
      end
      if (mode == 2) begin
        d[15:0] = 16'd7;
        d[47:32] = 16'd9;
      end
      nz = 0;
      for (int k = 0; k < 32; k++) if (d[k*16 +: 16] != 16'd0) nz++;
      f.d = d; f.sop = (j == 0); f.eop = (j == n_rule - 1); f.empty = '0;
      usr_q.push_back(f);
      if (j < MAXR) begin
        f.sop = 1'b0; f.eop = 1'b0;
        exp_q.push_back(f);
        rcnt += nz;
      end
    end
    ovf = (n_rule > MAXR);
    t = '0;
    t[511:496] = 16'(rcnt);
    t[495:480] = 16'(n_pkt);
    t[479:448] = m_seq;
    t[447:442] = 6'(le);
    t[441] = ovf;
    t[440] = err;
    f.d = t; f.sop = 1'b0; f.eop = 1'b1; f.empty = '0;
    exp_q.push_back(f);
    m_seq++; m_pkt++;
    m_rule += rcnt;
    if (ovf) m_ovf++;
    if (err) m_perr++;
  endtask

  task automatic step();
    bit f_meta, f_pkt, f_usr;
    flit_t obs;
    @(negedge clk);
    cyc++;
    obs = {out_data, out_sop, out_eop, out_empty};
    if (hold_v) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", obs, hold_f);
    end
    hold_v = out_valid && !out_ready;
    hold_f = obs;
    f_meta = in_meta_valid && in_meta_ready;
    f_pkt  = in_pkt_valid && in_pkt_ready;
    f_usr  = in_usr_valid && in_usr_ready;
    if (f_meta && ph_first_meta < 0) ph_first_meta = cyc;
    if (f_pkt) ph_pkt_fires++;
    if (out_valid && ph_first_out < 0) ph_first_out = cyc;
    if (out_valid && out_ready) begin
      ph_last_acc = cyc;
      ph_nacc++;
      if (exp_q.size() == 0) check("extra_flit", obs, '0);
      else check("out_flit", obs, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (f_meta) meta_q.delete(0);
    if (f_pkt) pkt_q.delete(0);
    if (f_usr) usr_q.delete(0);
    if (!in_meta_valid || f_meta) begin
      in_meta_valid = (meta_q.size() > 0) && ($urandom_range(99) < p_valid);
      if (in_meta_valid) in_meta_data = meta_q[0];
    end
    if (!in_pkt_valid || f_pkt) begin
      in_pkt_valid = (pkt_q.size() > 0) && ($urandom_range(99) < p_valid);
      if (in_pkt_valid) {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty} = pkt_q[0];
    end
    if (!in_usr_valid || f_usr) begin
      in_usr_valid = (usr_q.size() > 0) && ($urandom_range(99) < p_valid);
      if (in_usr_valid) begin
        in_usr_data = usr_q[0].d;
        in_usr_eop = usr_q[0].eop;
      end
    end
    out_ready = ($urandom_range(99) < p_ready);
  endtask

  task automatic phase_start();
    ph_first_out = -1; ph_first_meta = -1; ph_last_acc = -1; ph_nacc = 0; ph_pkt_fires = 0;
  endtask

  task automatic run_phase(input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || meta_q.size() > 0 || pkt_q.size() > 0 || usr_q.size() > 0)
           && c < budget) begin
      step();
      c++;
    end
    check("phase_timeout", exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stats_pkt"}, stats_pkt, m_pkt);
    check({tag, "_stats_rule"}, stats_rule, m_rule);
    check({tag, "_stats_ovf"}, stats_rule_ovf, m_ovf);
    check({tag, "_stats_perr"}, stats_proto_err, m_perr);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_flit"}, {out_data, out_sop, out_eop, out_empty}, '0);
    check({tag, "_readies"}, {in_meta_ready, in_pkt_ready, in_usr_ready}, 0);
    check({tag, "_stats"}, {stats_pkt, stats_rule, stats_rule_ovf, stats_proto_err}, 0);
  endtask

  initial begin
    #3;
    check_reset_state("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed single packet
    phase_start();
    p_valid = 100; p_ready = 100;
    gen_pkt(2, 1, 2, 0, 5);
    run_phase(200);
    check_stats("single");

    // rule overflow: 6 fully populated rule flits
    phase_start();
    gen_pkt(1, 6, 1, 0, -1);
    run_phase(200);
    check_stats("ovf");

    // framing errors: missing first sop, then a stray sop
    phase_start();
    gen_pkt(3, 2, 0, 1, -1);
    gen_pkt(3, 2, 0, 2, -1);
    run_phase(400);
    check_stats("frame");

    // back-to-back minimum packets
    phase_start();
    for (int i = 0; i < 10; i++) gen_pkt(1, 1, 0, 0, -1);
    run_phase(400);
    check("b2b_flits", ph_nacc, 40);
    check("b2b_span", ph_last_acc - ph_first_out + 1, 40);
    check("hdr_latency", ph_first_out - ph_first_meta, 1);
    check_stats("b2b");

    // randomized backpressure over 100 packets
    phase_start();
    p_valid = 70; p_ready = 50;
    for (int i = 0; i < 100; i++) begin
      int ek;
      ek = ($urandom_range(9) == 0) ? int'($urandom_range(2, 1)) : 0;
      gen_pkt($urandom_range(4, 1), $urandom_range(6, 1), 0, ek, -1);
    end
    run_phase(20000);
    check_stats("bp");

    // reset while in PKT
    phase_start();
    p_valid = 100; p_ready = 100;
    gen_pkt(3, 1, 0, 0, -1);
    for (int c = 0; c < 50 && ph_pkt_fires < 1; c++) step();
    check("rst_reach_pkt", ph_pkt_fires, 1);
    #1 rst_n = 1'b0;
    in_meta_valid = 1'b0; in_pkt_valid = 1'b0; in_usr_valid = 1'b0;
    meta_q.delete(); pkt_q.delete(); usr_q.delete(); exp_q.delete();
    #1;
    check_reset_state("midrst");
    m_seq = 0; m_pkt = 0; m_rule = 0; m_ovf = 0; m_perr = 0;
    hold_v = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    phase_start();
    gen_pkt(2, 2, 0, 0, -1);
    run_phase(200);
    check_stats("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
